// File: rtl/shift_seq_ctrl.sv
// Multi-pass sequencer that drives an external 8-bit right barrel shifter
// (at most 7 positions per pass). Optional macro: SHIFT_SEQ_SATURATE_EN.
module shift_seq_ctrl (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [7:0] i_data,
  input  logic [4:0] i_sa,
  input  logic       i_st,
  output logic [7:0] o_sh_data,
  output logic [2:0] o_sh_sa,
  output logic       o_sh_st,
  input  logic [7:0] i_sh_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_busy
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SA_W   = 5;
  localparam int unsigned PASS_W = 3;
  localparam logic [SA_W-1:0] MAX_PASS = SA_W'(7);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_work;
  logic [DATA_W-1:0]   w_work_nxt;
  logic [SA_W-1:0]     r_rem;
  logic [SA_W-1:0]     w_rem_nxt;
  logic                r_st;
  logic                w_st_nxt;
  logic [SA_W-1:0]     w_pass_sa;
  logic [SA_W-1:0]     w_rem_dec;
  logic                w_accept;

  // Amount applied by the current pass and what remains after it.
  assign w_pass_sa = (r_rem > MAX_PASS) ? MAX_PASS : r_rem;
  assign w_rem_dec = r_rem - w_pass_sa;
  assign w_accept  = i_valid & (r_state == S_IDLE) & ~i_rst;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_work  <= '0;
      r_rem   <= '0;
      r_st    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_work  <= w_work_nxt;
      r_rem   <= w_rem_nxt;
      r_st    <= w_st_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_work_nxt  = r_work;
    w_rem_nxt   = r_rem;
    w_st_nxt    = r_st;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_work_nxt = i_data;
          w_rem_nxt  = i_sa;
          w_st_nxt   = i_st;
          if (i_sa == '0) begin
            w_state_nxt = S_DONE;
`ifdef SHIFT_SEQ_SATURATE_EN
          end else if (i_sa >= SA_W'(DATA_W)) begin
            // Shifting out every bit leaves only fill bits; skip iterating.
            w_work_nxt  = {DATA_W{i_st & i_data[DATA_W-1]}};
            w_rem_nxt   = '0;
            w_state_nxt = S_DONE;
`endif
          end else begin
            w_state_nxt = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        w_work_nxt = i_sh_data;
        w_rem_nxt  = w_rem_dec;
        if (w_rem_dec == '0) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (i_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Handshake flags are pure state decodes; ready is also gated by reset.
  assign o_ready   = (r_state == S_IDLE) & ~i_rst;
  assign o_valid   = (r_state == S_DONE);
  assign o_busy    = (r_state == S_SHIFT) | (r_state == S_DONE);
  assign o_sh_sa   = (r_state == S_SHIFT) ? w_pass_sa[PASS_W-1:0] : '0;
  assign o_sh_data = r_work;
  assign o_sh_st   = r_st;
  assign o_data    = r_work;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed cases plus random commands
// against a whole-shift reference; also models the downstream barrel shifter.
module tb_shift_seq_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] i_data;
  logic [4:0] i_sa;
  logic       i_st;
  logic [7:0] o_sh_data;
  logic [2:0] o_sh_sa;
  logic       o_sh_st;
  logic [7:0] i_sh_data;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_data;
  logic       o_busy;

  int checks   = 0;
  int failures = 0;

  shift_seq_ctrl dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_data    (i_data),
    .i_sa      (i_sa),
    .i_st      (i_st),
    .o_sh_data (o_sh_data),
    .o_sh_sa   (o_sh_sa),
    .o_sh_st   (o_sh_st),
    .i_sh_data (i_sh_data),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_data    (o_data),
    .o_busy    (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Downstream combinational right barrel shifter.
  logic signed [7:0] sh_signed;
  always_comb begin
    sh_signed = o_sh_data;
    if (o_sh_st) i_sh_data = sh_signed >>> o_sh_sa;
    else         i_sh_data = o_sh_data >> o_sh_sa;
  end

  // Whole shift in one step with integer arithmetic.
  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [4:0] sa,
                                           input logic st);
    int v;
    v = (st && d[7]) ? (int'(d) - 256) : int'(d);
    return 8'(v >>> sa);
  endfunction

  function automatic int ref_latency(input logic [4:0] sa);
`ifdef SHIFT_SEQ_SATURATE_EN
    if (sa >= 5'd8) return 1;
`endif
    return 1 + (int'(sa) + 6) / 7;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command and follow it through to the result handshake.
  task automatic run_cmd(input logic [7:0] d, input logic [4:0] sa, input logic st,
                         input int bp);
    logic [2:0] seen[$];
    int         exp_seq[$];
    int         lat;
    int         rem;
    logic [7:0] exp_d;
    exp_d = ref_shift(d, sa, st);
    chk("ready_idle", 32'(o_ready), 32'd1);
    i_valid = 1'b1;
    i_data  = d;
    i_sa    = sa;
    i_st    = st;
    i_ready = 1'b0;
    @(posedge i_clk); #1;
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      if (o_valid) begin
        lat = n;
        break;
      end
      seen.push_back(o_sh_sa);
      i_valid = 1'(($urandom & 1));
      i_data  = 8'($urandom);
      i_sa    = 5'($urandom);
      i_st    = 1'(($urandom & 1));
      i_ready = 1'(($urandom & 1));
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    i_ready = 1'b0;
    chk("latency", 32'(lat), 32'(ref_latency(sa)));
    chk("result", 32'(o_data), 32'(exp_d));
    chk("busy_done", 32'(o_busy), 32'd1);
    chk("ready_done", 32'(o_ready), 32'd0);
    chk("sh_sa_done", 32'(o_sh_sa), 32'd0);
    rem = int'(sa);
`ifdef SHIFT_SEQ_SATURATE_EN
    if (sa >= 5'd8) rem = 0;
`endif
    while (rem > 0) begin
      exp_seq.push_back((rem > 7) ? 7 : rem);
      rem -= (rem > 7) ? 7 : rem;
    end
    chk("npass", 32'(seen.size()), 32'(exp_seq.size()));
    for (int i = 0; i < seen.size() && i < exp_seq.size(); i++)
      chk("pass_sa", 32'(seen[i]), 32'(exp_seq[i]));
    for (int c = 0; c < bp; c++) begin
      i_valid = 1'b1;
      i_data  = 8'($urandom);
      i_sa    = 5'($urandom);
      @(posedge i_clk); #1;
      chk("bp_valid", 32'(o_valid), 32'd1);
      chk("bp_data", 32'(o_data), 32'(exp_d));
      chk("bp_ready", 32'(o_ready), 32'd0);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    chk("release_valid", 32'(o_valid), 32'd0);
    chk("release_ready", 32'(o_ready), 32'd1);
    chk("release_busy", 32'(o_busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    i_sa    = '0;
    i_st    = 1'b0;
    i_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_sh_sa", 32'(o_sh_sa), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    run_cmd(8'hB4, 5'd3, 1'b0, 0);
    run_cmd(8'hB4, 5'd3, 1'b1, 0);
    run_cmd(8'h5A, 5'd0, 1'b0, 0);
    run_cmd(8'h80, 5'd7, 1'b0, 0);
    run_cmd(8'h80, 5'd8, 1'b0, 0);
    run_cmd(8'h80, 5'd20, 1'b1, 0);
    run_cmd(8'hB4, 5'd3, 1'b0, 5);
    run_cmd(8'h80, 5'd31, 1'b1, 0);
    run_cmd(8'h7F, 5'd9, 1'b1, 0);
    run_cmd(8'hFF, 5'd31, 1'b0, 1);

    // Asynchronous reset in the middle of a long command.
    i_valid = 1'b1;
    i_data  = 8'hC3;
    i_sa    = 5'd31;
    i_st    = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    @(posedge i_clk); #2;
    i_rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_data", 32'(o_data), 32'd0);
    chk("mid_rst_ready", 32'(o_ready), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    @(posedge i_clk); #1;
    chk("mid_rst_hold", 32'(o_valid), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(o_ready), 32'd1);
    @(posedge i_clk); #1;
    run_cmd(8'h96, 5'd5, 1'b1, 0);

    for (int k = 0; k < 40; k++) begin
      run_cmd(8'($urandom), 5'($urandom), 1'(($urandom & 1)), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Multi-pass shift sequencer that sits directly upstream of the 8-bit combinational right barrel shifter and drives its data, shift-amount and shift-type inputs. It accepts shift commands with amounts of 0..31 over a valid/ready handshake. It iterates the downstream shifter, at most 7 positions per pass, feeding each result back into a work register. The final result is presented on a valid/ready output port.

## Interface
Parameters:
- none; data width fixed at 8, command shift amount fixed at 5 bits, per-pass amount fixed at 3 bits.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_valid  input  1  command valid.
- o_ready  output  1  command accepted when i_valid & o_ready at a rising edge.
- i_data  input  8  operand.
- i_sa  input  5  total right-shift amount, 0..31.
- i_st  input  1  shift type: 0 logical, 1 arithmetic.
- o_sh_data  output  8  operand to downstream shifter; equals work register.
- o_sh_sa  output  3  per-pass amount to downstream shifter.
- o_sh_st  output  1  shift type to downstream shifter; equals latched type.
- i_sh_data  input  8  combinational result returned by downstream shifter.
- o_valid  output  1  result valid.
- i_ready  input  1  result consumed when o_valid & i_ready at a rising edge.
- o_data  output  8  result; equals work register.
- o_busy  output  1  high in SHIFT or DONE.

## Operation
- Registers: state (IDLE, SHIFT, DONE), work[7:0], rem[4:0], st.
- IDLE:
  - o_ready = 1 while i_rst is low.
  - On accept: work <= i_data, rem <= i_sa, st <= i_st.
  - Next state is DONE if i_sa == 0, else SHIFT.
- SHIFT:
  - o_sh_sa = min(rem, 7); o_sh_st = st.
  - Each edge: work <= i_sh_data, rem <= rem - o_sh_sa.
  - Next state is DONE when rem - o_sh_sa == 0, else stay in SHIFT.
- DONE:
  - o_valid = 1; o_data holds stable.
  - On i_ready the block returns to IDLE.
  - o_ready is 0, so a new command cannot be accepted in the same cycle.
- Outside SHIFT, o_sh_sa = 0.
- Fill bits come from the downstream shifter (st & bit 7). Repeated arithmetic passes therefore replicate the sign correctly; logical passes fill with zeros.
- Inputs sampled only at accept; i_data/i_sa/i_st changes afterwards have no effect.
- o_valid, o_ready and o_busy are decoded from state. work and rem are registered.

## Timing
- Reset, asynchronous:
  - state = IDLE, work = 0, rem = 0, st = 0.
  - o_valid = 0, o_ready = 0 while i_rst is high, o_data = 0, o_sh_sa = 0, o_busy = 0.
- Reset mid-operation aborts the command; no result is produced.
- Latency from the accept edge to o_valid high is 1 + ceil(i_sa/7) cycles:
  - sa = 0: 1 cycle.
  - sa = 1..7: 2 cycles.
  - sa = 8..14: 3 cycles.
  - sa = 31: 6 cycles.
- Minimum command spacing is latency + 1 cycles when i_ready is held high.
- Back-pressure: o_valid and o_data hold indefinitely while i_ready = 0.
- i_ready asserted while o_valid = 0 has no effect.

## Configuration
- SHIFT_SEQ_SATURATE_EN defined:
  - A command with i_sa >= 8 skips SHIFT entirely.
  - At accept: work <= {8{i_st & i_data[7]}}, next state DONE, latency 1 cycle.
  - i_sa 0..7 behaves as without the macro.
- SHIFT_SEQ_SATURATE_EN undefined: every amount is iterated as above. Results are identical either way; only latency differs.

## Test plan
- Reset: hold i_rst high mid-SHIFT -> o_valid = 0, o_data = 0, o_ready = 0. Release -> o_ready = 1, next command processes normally.
- Single pass: i_data = 0xB4, i_sa = 3.
  - i_st = 0 -> o_data = 0x16 with o_valid 2 cycles after accept.
  - i_st = 1 -> o_data = 0xF6 with o_valid 2 cycles after accept.
- Zero shift: i_data = 0x5A, i_sa = 0 -> o_data = 0x5A, latency 1, o_sh_sa stays 0.
- Multi-pass (macro undefined):
  - 0x80, st = 0, sa = 7 -> 0x01, latency 2.
  - 0x80, st = 0, sa = 8 -> 0x00, latency 3, o_sh_sa sequence 7,1.
  - 0x80, st = 1, sa = 20 -> 0xFF, latency 4, sequence 7,7,6.
- Back-pressure: hold i_ready = 0 for 5 cycles in DONE -> o_valid and o_data stable, o_ready = 0, i_valid ignored. Release -> IDLE next cycle.
- Macro defined: 0x80, st = 1, sa = 31 -> 0xFF, latency 1. 0x7F, st = 1, sa = 9 -> 0x00, latency 1.
